// File: rtl/fwd_scoreboard_if.sv
// EX-stage <-> forwarding scoreboard bus: instruction fields in, operand selects and interlock out.
interface fwd_scoreboard_if #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 3
);
    localparam int unsigned SELW = $clog2(DEPTH + 1);

    logic                        ex_valid;
    logic [NUM_SRC*REG_AW-1:0]   ex_src;
    logic [REG_AW-1:0]           ex_rd;
    logic                        ex_wr;
    logic                        ex_is_load;
    logic                        flush;
    logic [NUM_SRC*SELW-1:0]     fwd_sel;
    logic                        stall;
    logic [31:0]                 perf_stall_cnt;
    logic [31:0]                 perf_fwd_cnt;

    modport master (
        output ex_valid, ex_src, ex_rd, ex_wr, ex_is_load, flush,
        input  fwd_sel, stall, perf_stall_cnt, perf_fwd_cnt
    );

    modport slave (
        input  ex_valid, ex_src, ex_rd, ex_wr, ex_is_load, flush,
        output fwd_sel, stall, perf_stall_cnt, perf_fwd_cnt
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding select and load-use interlock over a DEPTH-stage write scoreboard.
// Optional perf counters are built only when FWD_PERF_CNT_EN is defined.
module fwd_scoreboard #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_STAGE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_scoreboard_if.slave   bus
);
    localparam int unsigned SELW = $clog2(DEPTH + 1);
    localparam int unsigned CNTW = 32;

    // Index 0 holds stage 1 (EX/MEM), index DEPTH-1 the oldest tracked stage.
    logic [DEPTH-1:0]   v_q, v_d;
    logic [DEPTH-1:0]   ld_q, ld_d;
    logic [REG_AW-1:0]  rd_q [DEPTH];
    logic [REG_AW-1:0]  rd_d [DEPTH];

    logic [REG_AW-1:0]  src_c     [NUM_SRC];
    logic [SELW-1:0]    win_sel_c [NUM_SRC];
    logic [NUM_SRC-1:0] hit_c;
    logic [NUM_SRC-1:0] rdy_c;
    logic [NUM_SRC-1:0] blocked_c;
    logic               stall_c;
    logic               push_v_c;

    // Youngest matching producer per source; older stages never override it.
    always_comb begin
        hit_c     = '0;
        rdy_c     = '0;
        blocked_c = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src_c[i]     = bus.ex_src[i*REG_AW +: REG_AW];
            win_sel_c[i] = '0;
            for (int unsigned s = 0; s < DEPTH; s++) begin
                if (!hit_c[i] && v_q[s] && (rd_q[s] == src_c[i]) && (src_c[i] != '0)) begin
                    hit_c[i]     = 1'b1;
                    win_sel_c[i] = SELW'(s + 1);
                    rdy_c[i]     = !ld_q[s] || ((s + 1) >= LOAD_STAGE);
                end
            end
            blocked_c[i] = hit_c[i] && !rdy_c[i];
        end
    end

    // Interlock and operand selects; flush suppresses the stall, reset silences both.
    always_comb begin
        stall_c     = rst_n && bus.ex_valid && !bus.flush && (|blocked_c);
        bus.fwd_sel = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (rst_n && bus.ex_valid && !stall_c && hit_c[i] && rdy_c[i]) begin
                bus.fwd_sel[i*SELW +: SELW] = win_sel_c[i];
            end
        end
    end

    assign bus.stall = stall_c;

    // Scoreboard shifts every cycle; stalled or flushed instructions enter as bubbles.
    always_comb begin
        push_v_c = bus.ex_valid && bus.ex_wr && (bus.ex_rd != '0) && !bus.flush && !stall_c;
        v_d      = {v_q[DEPTH-2:0], push_v_c};
        ld_d     = {ld_q[DEPTH-2:0], bus.ex_is_load};
        rd_d[0]  = bus.ex_rd;
        for (int unsigned s = 1; s < DEPTH; s++) begin
            rd_d[s] = rd_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q  <= '0;
            ld_q <= '0;
            for (int unsigned s = 0; s < DEPTH; s++) begin
                rd_q[s] <= '0;
            end
        end else begin
            v_q  <= v_d;
            ld_q <= ld_d;
            for (int unsigned s = 0; s < DEPTH; s++) begin
                rd_q[s] <= rd_d[s];
            end
        end
    end

`ifdef FWD_PERF_CNT_EN
    localparam int unsigned FCW = $clog2(NUM_SRC + 1);

    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0] fwd_cnt_q, fwd_cnt_d;
    logic [FCW-1:0]  fwd_inc_c;
    logic [CNTW:0]   fwd_sum_c;

    // Saturating counters: the extra sum bit detects overflow past all-ones.
    always_comb begin
        fwd_inc_c = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (bus.fwd_sel[i*SELW +: SELW] != '0) begin
                fwd_inc_c = fwd_inc_c + FCW'(1);
            end
        end
        fwd_sum_c = {1'b0, fwd_cnt_q} + (CNTW+1)'(fwd_inc_c);
        fwd_cnt_d = fwd_sum_c[CNTW] ? '1 : fwd_sum_c[CNTW-1:0];

        stall_cnt_d = stall_cnt_q;
        if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign bus.perf_stall_cnt = stall_cnt_q;
    assign bus.perf_fwd_cnt   = fwd_cnt_q;
`else
    assign bus.perf_stall_cnt = '0;
    assign bus.perf_fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed table-driven bench for fwd_scoreboard at defaults (NUM_SRC=2, DEPTH=3, LOAD_STAGE=2).
module tb_fwd_scoreboard;
    localparam int unsigned NV = 18;

    logic clk;
    logic rst_n;

    fwd_scoreboard_if #(.REG_AW(5), .NUM_SRC(2), .DEPTH(3)) bus ();

    fwd_scoreboard #(
        .REG_AW(5), .NUM_SRC(2), .DEPTH(3), .LOAD_STAGE(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] s0;
        logic [4:0] s1;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       fl;
        logic       e_stall;
        logic [1:0] e0;
        logic [1:0] e1;
    } vec_t;

    vec_t vecs [NV];
    int   n_tests;
    int   n_fail;
    int   exp_stall_cnt;
    int   exp_fwd_cnt;

    function automatic vec_t mk(int valid, int s0, int s1, int rd, int wr, int ld, int fl,
                                int st, int e0, int e1);
        vec_t v;
        v.valid   = 1'(valid);
        v.s0      = 5'(s0);
        v.s1      = 5'(s1);
        v.rd      = 5'(rd);
        v.wr      = 1'(wr);
        v.ld      = 1'(ld);
        v.fl      = 1'(fl);
        v.e_stall = 1'(st);
        v.e0      = 2'(e0);
        v.e1      = 2'(e1);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.ex_valid   = v.valid;
        bus.ex_src     = {v.s1, v.s0};
        bus.ex_rd      = v.rd;
        bus.ex_wr      = v.wr;
        bus.ex_is_load = v.ld;
        bus.flush      = v.fl;
    endtask

    task automatic drive_idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        exp_stall_cnt = 0;
        exp_fwd_cnt   = 0;

        //               vld s0  s1  rd  wr ld fl  stall sel0 sel1
        vecs[0]  = mk(1,  1,  2,  5, 1, 0, 0,  0, 0, 0);
        vecs[1]  = mk(1,  5,  5,  6, 1, 0, 0,  0, 1, 1);
        vecs[2]  = mk(1,  5,  6,  7, 1, 0, 0,  0, 2, 1);
        vecs[3]  = mk(0,  5,  6,  0, 0, 0, 0,  0, 0, 0);
        vecs[4]  = mk(1,  7,  6,  8, 1, 0, 0,  0, 2, 3);
        vecs[5]  = mk(1,  6,  7,  9, 1, 0, 0,  0, 0, 3);
        vecs[6]  = mk(1,  9,  8,  4, 1, 0, 0,  0, 1, 2);
        vecs[7]  = mk(1,  8,  4,  4, 1, 0, 0,  0, 3, 1);
        vecs[8]  = mk(1,  9,  4,  9, 1, 0, 0,  0, 3, 1);
        vecs[9]  = mk(1,  4,  0,  0, 1, 0, 0,  0, 2, 0);
        vecs[10] = mk(1,  0,  9,  6, 1, 0, 1,  0, 0, 2);
        vecs[11] = mk(1,  6,  9,  3, 1, 1, 0,  0, 0, 3);
        vecs[12] = mk(1,  3,  9, 10, 1, 0, 0,  1, 0, 0);
        vecs[13] = mk(1,  3,  9, 10, 1, 0, 0,  0, 2, 0);
        vecs[14] = mk(1, 10,  3, 11, 1, 1, 0,  0, 1, 3);
        vecs[15] = mk(1, 11, 10, 12, 1, 0, 1,  0, 0, 2);
        vecs[16] = mk(1, 10, 11, 13, 1, 0, 0,  0, 3, 2);
        vecs[17] = mk(1, 12, 12,  0, 0, 0, 0,  0, 0, 0);

        // Reset with active-looking inputs: outputs must stay quiet.
        rst_n = 1'b0;
        drive(mk(1, 5, 5, 5, 1, 1, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        #1;
        check("in_reset stall", 32'(bus.stall), 32'd0);
        check("in_reset fwd_sel", 32'(bus.fwd_sel), 32'd0);
        rst_n = 1'b1;
        drive_idle();
        #1;
        check("post_reset stall", 32'(bus.stall), 32'd0);
        check("post_reset perf_stall", bus.perf_stall_cnt, 32'd0);
        check("post_reset perf_fwd", bus.perf_fwd_cnt, 32'd0);

        for (int i = 0; i < int'(NV); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
            check($sformatf("v%0d sel0", i), 32'(bus.fwd_sel[1:0]), 32'(vecs[i].e0));
            check($sformatf("v%0d sel1", i), 32'(bus.fwd_sel[3:2]), 32'(vecs[i].e1));
            exp_stall_cnt += int'(vecs[i].e_stall);
            exp_fwd_cnt   += int'(vecs[i].e0 != 2'd0) + int'(vecs[i].e1 != 2'd0);
        end
        @(negedge clk);
        drive_idle();
        #1;
`ifdef FWD_PERF_CNT_EN
        check("perf_stall_cnt", bus.perf_stall_cnt, 32'(exp_stall_cnt));
        check("perf_fwd_cnt", bus.perf_fwd_cnt, 32'(exp_fwd_cnt));
`else
        check("perf_stall_cnt tied", bus.perf_stall_cnt, 32'd0);
        check("perf_fwd_cnt tied", bus.perf_fwd_cnt, 32'd0);
`endif

        // Load-use stall interrupted by reset: pending producer must be dropped.
        @(negedge clk);
        drive(mk(1, 0, 0, 3, 1, 1, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk(1, 3, 3, 4, 1, 0, 0, 0, 0, 0));
        #1;
        check("rst_seq stall before", 32'(bus.stall), 32'd1);
        check("rst_seq sel before", 32'(bus.fwd_sel), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_seq stall in reset", 32'(bus.stall), 32'd0);
        check("rst_seq sel in reset", 32'(bus.fwd_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_seq stall after", 32'(bus.stall), 32'd0);
        check("rst_seq sel after", 32'(bus.fwd_sel), 32'd0);
        check("rst_seq perf_stall", bus.perf_stall_cnt, 32'd0);
        check("rst_seq perf_fwd", bus.perf_fwd_cnt, 32'd0);

        // Back-to-back ALU after reset: fresh producer forwards from stage 1.
        @(negedge clk);
        drive(mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk(1, 5, 1, 6, 1, 0, 0, 0, 0, 0));
        #1;
        check("b2b stall", 32'(bus.stall), 32'd0);
        check("b2b sel0", 32'(bus.fwd_sel[1:0]), 32'd1);
        check("b2b sel1", 32'(bus.fwd_sel[3:2]), 32'd0);
        @(negedge clk);
        drive_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding and load-use interlock unit for the pipelined datapath. It tracks every in-flight register write in a DEPTH-stage shift-register scoreboard, selects per-source forwarding from the youngest matching producer, and raises a stall when that producer's data is not yet available. It sits beside ID/EX and drives the EX-stage operand muxes and the ID/IF hold logic.

## Interface
- `REG_AW`, 5: register-address width.
- `NUM_SRC`, 2: source operands checked per EX instruction.
- `DEPTH`, 3: post-EX stages tracked (stage 1 = EX/MEM, 2 = MEM/WB, 3 = WB/retire). Minimum 2.
- `LOAD_STAGE`, 2: first stage at which a load result is forwardable. Range 1..DEPTH.
- `SELW`, derived: $clog2(DEPTH+1).

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: **synchronous, active-low reset**.
- `ex_valid` in 1: EX holds a real instruction.
- `ex_src` in NUM_SRC*REG_AW: source register numbers; source i is bits [i*REG_AW +: REG_AW].
- `ex_rd` in REG_AW: destination register.
- `ex_wr` in 1: EX instruction writes `ex_rd`.
- `ex_is_load` in 1: EX instruction is a load.
- `flush` in 1: kill the EX instruction this cycle.
- `fwd_sel` out NUM_SRC*SELW: per source, 0 = register file, k = forward from stage k.
- `stall` out 1: hold IF/ID/EX this cycle.
- `perf_stall_cnt` out 32: stall cycles counted.
- `perf_fwd_cnt` out 32: forwarded operands counted.

## Operation
- Scoreboard entry per stage s in 1..DEPTH: {v, rd, ld}.
- Match for source i at stage s: v[s], rd[s] == src_i, src_i != 0.
- Youngest (lowest s) match wins. No other stage affects the result, including a non-matching or non-writing younger stage.
- Entry ready if !ld[s] or s >= LOAD_STAGE.
- Source i is blocked if its winning entry is not ready.
- `stall` = ex_valid & !flush & (any source blocked).
- `fwd_sel[i]` = winning s if a match exists and it is ready, else 0. `fwd_sel` is forced to 0 while `stall` = 1.
- Push value = {ex_valid & ex_wr & (ex_rd != 0) & !flush & !stall, ex_rd, ex_is_load}. A stall or flush therefore pushes a bubble.
- Shift every cycle: stage s+1 <= stage s, stage 1 <= push value. The DEPTH entry is discarded.
- Instructions are not held in the scoreboard during a stall. The consumer stays in EX while its producer advances, so a load-use stall lasts exactly LOAD_STAGE-1 cycles.
- `ex_valid` = 0: `fwd_sel` = 0 and `stall` = 0. The scoreboard still shifts.

## Timing
- `fwd_sel` and `stall` are combinational from scoreboard state and EX inputs, with zero-cycle latency. Scoreboard and counters update on the rising edge.
- Reset (`rst_n` = 0 at an edge): all v <= 0, rd <= 0, ld <= 0, counters <= 0.
  - While in reset, `fwd_sel` = 0 and `stall` = 0 regardless of inputs.
  - Reset mid-stall drops all pending producers. No stall is present in the cycle after reset.
- Flush and stall in the same cycle: flush wins. `stall` = 0 and a bubble is pushed.
- Two sources naming the same register get identical `fwd_sel`.
- Counters saturate at 32'hFFFF_FFFF and never wrap.
  - `perf_stall_cnt` += 1 per cycle with `stall` = 1.
  - `perf_fwd_cnt` += number of sources with nonzero `fwd_sel`.

## Configuration
- `FWD_PERF_CNT_EN` defined: both counters are implemented as specified.
- Not defined: no counter flops are built. `perf_stall_cnt` and `perf_fwd_cnt` are tied to 0, and the ports remain present.

## Test plan
Defaults used: NUM_SRC=2, DEPTH=3, LOAD_STAGE=2.
- **Back-to-back ALU:** `add r5` then `add` with src0=r5 -> `fwd_sel[0]`=1, `stall`=0.
- **Distance 2 and 3:** producer of r7 two instructions earlier -> sel 2; three earlier -> sel 3; four earlier -> sel 0.
- **Priority:** r4 written at stage 1 and stage 2, src1=r4 -> sel 1. A stage-1 writer of r9 with src=r4 at stage 2 -> sel 2. The unrelated younger write does not block.
- **Load-use:** `lw r3` then a consumer of r3 -> `stall`=1 for exactly 1 cycle with `fwd_sel`=0. The next cycle gives sel 2 and `stall`=0. `perf_stall_cnt` = 1 with the macro defined, 0 without.
- **r0 and flush:** a producer writing r0 gives sel 0 for a src=r0 consumer. A flushed `add r6` leaves a bubble, so the next consumer of r6 gets sel 0.
- **Reset:** `rst_n`=0 for one edge during a load-use stall -> next cycle `stall`=0, all `fwd_sel`=0, counters 0.
